// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the integer execution unit and the ALU controller
// that produces its control codes.
//   - alu_ctrl_e : 4-bit ALU control codes (any code not listed is illegal)
//   - mem_size_e : memory access size carried alongside address generation
//   - default operand / tag widths
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int TAG_W_DEF = 4;

  typedef enum logic [3:0] {
    ALU_OR      = 4'b0001,
    ALU_ADD     = 4'b0010,
    ALU_XOR     = 4'b0011,
    ALU_SUB     = 4'b0110,
    ALU_SRA     = 4'b0111,
    ALU_LUI     = 4'b1000,
    ALU_INVALID = 4'b1111
  } alu_ctrl_e;

  typedef enum logic {
    MEM_BYTE = 1'b0,
    MEM_WORD = 1'b1
  } mem_size_e;

endpackage

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU datapath sitting between the S1 and S2 pipeline
// registers of alu_exec_unit.
// Ports:
//   ctrl_i   : 4-bit ALU control code
//   a_i      : operand A
//   b_i      : operand B (register or sign-extended immediate)
//   result_o : computed value (0 for illegal codes)
//   exc_o    : high when ctrl_i is not a recognised code
// -----------------------------------------------------------------------------
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [3:0]      ctrl_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o,
  output logic            exc_o
);

  localparam int SHW = $clog2(XLEN);

  logic signed [XLEN-1:0] a_signed;

  assign a_signed = a_i;

  always_comb begin
    result_o = '0;
    exc_o    = 1'b0;
    case (ctrl_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      ALU_OR:  result_o = a_i | b_i;
      // Only the low log2(XLEN) bits of B form the shift amount.
      ALU_SRA: result_o = a_signed >>> b_i[SHW-1:0];
      ALU_LUI: result_o = XLEN'({b_i[19:0], 12'h000});
      default: begin
        result_o = '0;
        exc_o    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
// Two-stage pipelined integer execution unit. S1 captures the issued micro-op,
// alu_core computes between S1 and S2, and S2 holds the result until the CDB
// arbiter grants a broadcast slot.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   flush             : synchronous kill of both stages (branch mispredict)
//   issue_*           : issued op (valid/ready, ctrl, mem size, is_mem, A, B, tag)
//   cdb_req/cdb_grant : broadcast request / same-cycle grant
//   cdb_*             : payload of the pending result, straight from S2
//
// Handshake semantics: a transfer happens on a rising edge where both sides
// of a pair are high (issue_valid & issue_ready, cdb_req & cdb_grant).
// issue_ready depends combinationally on cdb_grant, so a full pipeline still
// accepts a new op in the cycle its oldest result is granted. cdb_grant
// without cdb_req is ignored. A producer holds its payload stable while
// valid is high and not yet accepted.
// -----------------------------------------------------------------------------
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [3:0]       issue_alu_ctrl,
  input  logic             issue_mem_size,
  input  logic             issue_is_mem,
  input  logic [XLEN-1:0]  issue_a,
  input  logic [XLEN-1:0]  issue_b,
  input  logic [TAG_W-1:0] issue_tag,
  output logic             cdb_req,
  input  logic             cdb_grant,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [XLEN-1:0]  cdb_result,
  output logic             cdb_is_mem,
  output logic             cdb_mem_size,
  output logic             cdb_exc
);

  // S1 stage
  logic             s1_valid_q, s1_valid_d;
  logic [3:0]       s1_ctrl_q;
  logic             s1_mem_size_q;
  logic             s1_is_mem_q;
  logic [XLEN-1:0]  s1_a_q;
  logic [XLEN-1:0]  s1_b_q;
  logic [TAG_W-1:0] s1_tag_q;

  // S2 stage
  logic             s2_valid_q, s2_valid_d;
  logic [XLEN-1:0]  s2_result_q;
  logic [TAG_W-1:0] s2_tag_q;
  logic             s2_is_mem_q;
  logic             s2_mem_size_q;
  logic             s2_exc_q;

  // Advance control
  logic             s2_free;
  logic             s1_move;
  logic             accept;

  // ALU outputs
  logic [XLEN-1:0]  alu_result;
  logic             alu_exc;

  assign s2_free     = !s2_valid_q || cdb_grant;
  assign s1_move     = s1_valid_q && s2_free;
  assign issue_ready = !s1_valid_q || s1_move;
  assign accept      = issue_valid && issue_ready;

  // Flush wins over any simultaneous issue or grant.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (accept) begin
        s1_valid_d = 1'b1;
      end else if (s1_move) begin
        s1_valid_d = 1'b0;
      end
      if (s1_move) begin
        s2_valid_d = 1'b1;
      end else if (s2_valid_q && cdb_grant) begin
        s2_valid_d = 1'b0;
      end
    end
  end

  alu_core #(
    .XLEN(XLEN)
  ) u_alu_core (
    .ctrl_i  (s1_ctrl_q),
    .a_i     (s1_a_q),
    .b_i     (s1_b_q),
    .result_o(alu_result),
    .exc_o   (alu_exc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s2_valid_q    <= 1'b0;
      // S2 payload is cleared only so the CDB outputs are defined after reset.
      s2_result_q   <= '0;
      s2_tag_q      <= '0;
      s2_is_mem_q   <= 1'b0;
      s2_mem_size_q <= 1'b0;
      s2_exc_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s1_move) begin
        s2_result_q   <= alu_result;
        s2_tag_q      <= s1_tag_q;
        s2_is_mem_q   <= s1_is_mem_q;
        s2_mem_size_q <= s1_mem_size_q;
        s2_exc_q      <= alu_exc;
      end
    end
  end

  // S1 payload carries no reset; it is qualified by s1_valid_q.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_ctrl_q     <= issue_alu_ctrl;
      s1_mem_size_q <= issue_mem_size;
      s1_is_mem_q   <= issue_is_mem;
      s1_a_q        <= issue_a;
      s1_b_q        <= issue_b;
      s1_tag_q      <= issue_tag;
    end
  end

  assign cdb_req      = s2_valid_q;
  assign cdb_tag      = s2_tag_q;
  assign cdb_result   = s2_result_q;
  assign cdb_is_mem   = s2_is_mem_q;
  assign cdb_mem_size = s2_mem_size_q;
  assign cdb_exc      = s2_exc_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;
  localparam int EW    = TAG_W + 3 + XLEN;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             issue_valid;
  logic             issue_ready;
  logic [3:0]       issue_alu_ctrl;
  logic             issue_mem_size;
  logic             issue_is_mem;
  logic [XLEN-1:0]  issue_a;
  logic [XLEN-1:0]  issue_b;
  logic [TAG_W-1:0] issue_tag;
  logic             cdb_req;
  logic             cdb_grant;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_result;
  logic             cdb_is_mem;
  logic             cdb_mem_size;
  logic             cdb_exc;

  alu_exec_unit #(
    .XLEN (XLEN),
    .TAG_W(TAG_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_alu_ctrl(issue_alu_ctrl),
    .issue_mem_size(issue_mem_size),
    .issue_is_mem  (issue_is_mem),
    .issue_a       (issue_a),
    .issue_b       (issue_b),
    .issue_tag     (issue_tag),
    .cdb_req       (cdb_req),
    .cdb_grant     (cdb_grant),
    .cdb_tag       (cdb_tag),
    .cdb_result    (cdb_result),
    .cdb_is_mem    (cdb_is_mem),
    .cdb_mem_size  (cdb_mem_size),
    .cdb_exc       (cdb_exc)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: in-order list of ops in flight, with edges elapsed since accept.
  // An op can be broadcast once two edges have passed since it was accepted;
  // the unit can hold at most two ops, but accepts when the oldest is granted.
  // Entry packing: {tag, exc, is_mem, mem_size, result}
  // ---------------------------------------------------------------------------
  logic [EW-1:0] exp_q[$];
  int            age_q[$];
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Returns {exc, result} from the instruction-set meaning of each code.
  function automatic logic [XLEN:0] ref_alu(input logic [3:0] c,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic [XLEN-1:0]        r;
    sa = a;
    case (c)
      4'b0010: return {1'b0, a + b};
      4'b0110: return {1'b0, a - b};
      4'b0011: return {1'b0, a ^ b};
      4'b0001: return {1'b0, a | b};
      4'b0111: begin
        r = sa >>> (b % XLEN);
        return {1'b0, r};
      end
      4'b1000: begin
        r = b << 12;
        return {1'b0, r};
      end
      default: return {1'b1, {XLEN{1'b0}}};
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one clock cycle. Inputs change on the falling edge, outputs are
  // checked 1 time unit later, then the model advances for the rising edge.
  // ---------------------------------------------------------------------------
  task automatic cycle(input bit v, input logic [3:0] ctrl, input logic ms, input logic im,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [TAG_W-1:0] tag, input bit g, input bit fl,
                       input bit use_exp, input logic [XLEN:0] exp_xr);
    logic [XLEN:0] xr;
    bit            exp_req;
    bit            exp_rdy;
    @(negedge clk);
    issue_valid    = v;
    issue_alu_ctrl = ctrl;
    issue_mem_size = ms;
    issue_is_mem   = im;
    issue_a        = a;
    issue_b        = b;
    issue_tag      = tag;
    cdb_grant      = g;
    flush          = fl;
    #1;
    exp_req = (exp_q.size() > 0) && (age_q[0] >= 2);
    exp_rdy = (exp_q.size() < 2) || g;
    check("cdb_req", cdb_req, exp_req);
    check("issue_ready", issue_ready, exp_rdy);
    if (exp_req)
      check("cdb_payload", {cdb_tag, cdb_exc, cdb_is_mem, cdb_mem_size, cdb_result}, exp_q[0]);
    if (fl) begin
      exp_q.delete();
      age_q.delete();
    end else begin
      if (exp_req && g) begin
        void'(exp_q.pop_front());
        void'(age_q.pop_front());
      end
      foreach (age_q[i]) age_q[i]++;
      if (v && exp_rdy) begin
        xr = use_exp ? exp_xr : ref_alu(ctrl, a, b);
        exp_q.push_back({tag, xr[XLEN], im, ms, xr[XLEN-1:0]});
        age_q.push_back(1);
      end
    end
    @(posedge clk);
  endtask

  task automatic op(input logic [3:0] ctrl, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                    input logic [TAG_W-1:0] tag, input bit g, input logic [XLEN:0] exp_xr);
    cycle(1'b1, ctrl, 1'b0, 1'b0, a, b, tag, g, 1'b0, 1'b1, exp_xr);
  endtask

  task automatic idle(input int n, input bit g);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 4'h0, 1'b0, 1'b0, '0, '0, '0, g, 1'b0, 1'b0, '0);
  endtask

  task automatic check_reset_outputs(input string where);
    check({where, "_req"}, cdb_req, 1'b0);
    check({where, "_ready"}, issue_ready, 1'b1);
    check({where, "_tag"}, cdb_tag, '0);
    check({where, "_result"}, cdb_result, '0);
    check({where, "_flags"}, {cdb_is_mem, cdb_mem_size, cdb_exc}, 3'b000);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [3:0] code_tab[12] = '{4'b0010, 4'b0110, 4'b0011, 4'b0001, 4'b0111, 4'b1000,
                               4'b1111, 4'b0000, 4'b0100, 4'b0101, 4'b1001, 4'b1100};

  initial begin
    rst            = 1'b1;
    flush          = 1'b0;
    issue_valid    = 1'b0;
    issue_alu_ctrl = '0;
    issue_mem_size = 1'b0;
    issue_is_mem   = 1'b0;
    issue_a        = '0;
    issue_b        = '0;
    issue_tag      = '0;
    cdb_grant      = 1'b0;
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single ADD with grant held: request two edges after accept.
    op(ALU_ADD, 32'd7, 32'd5, 4'd3, 1'b1, {1'b0, 32'd12});
    idle(3, 1'b1);

    // Back-to-back ops, one per cycle.
    op(ALU_SUB, 32'h0, 32'h1, 4'd1, 1'b1, {1'b0, 32'hFFFF_FFFF});
    op(ALU_XOR, 32'hF0F0, 32'h0FF0, 4'd2, 1'b1, {1'b0, 32'h0000_FF00});
    op(ALU_OR, 32'h1, 32'h2, 4'd4, 1'b1, {1'b0, 32'h3});
    op(ALU_SRA, 32'h8000_0000, 32'd4, 4'd5, 1'b1, {1'b0, 32'hF800_0000});
    op(ALU_LUI, 32'h0, 32'h12345, 4'd6, 1'b1, {1'b0, 32'h1234_5000});
    idle(3, 1'b1);

    // Illegal code, then a word-sized address generation.
    op(ALU_INVALID, 32'hDEAD_BEEF, 32'h1234, 4'd9, 1'b1, {1'b1, 32'h0});
    cycle(1'b1, ALU_ADD, 1'b1, 1'b1, 32'h100, 32'h4, 4'd10, 1'b1, 1'b0, 1'b1, {1'b0, 32'h104});
    idle(3, 1'b1);

    // Backpressure: grant low for 5 cycles while 3 ops are offered.
    op(ALU_ADD, 32'd1, 32'd1, 4'd11, 1'b0, {1'b0, 32'd2});
    op(ALU_ADD, 32'd2, 32'd2, 4'd12, 1'b0, {1'b0, 32'd4});
    for (int i = 0; i < 3; i++)
      op(ALU_ADD, 32'd3, 32'd3, 4'd13, 1'b0, {1'b0, 32'd6});
    op(ALU_ADD, 32'd3, 32'd3, 4'd13, 1'b1, {1'b0, 32'd6});
    idle(4, 1'b1);

    // Flush with both stages full and a new op offered.
    op(ALU_OR, 32'h10, 32'h01, 4'd1, 1'b0, {1'b0, 32'h11});
    op(ALU_OR, 32'h20, 32'h02, 4'd2, 1'b0, {1'b0, 32'h22});
    cycle(1'b1, ALU_OR, 1'b0, 1'b0, 32'h40, 32'h04, 4'd3, 1'b0, 1'b1, 1'b1, {1'b0, 32'h44});
    idle(4, 1'b1);

    // Asynchronous reset mid-stream with both stages valid.
    op(ALU_XOR, 32'hAAAA, 32'h5555, 4'd7, 1'b0, {1'b0, 32'hFFFF});
    op(ALU_SUB, 32'd9, 32'd4, 4'd8, 1'b0, {1'b0, 32'd5});
    idle(1, 1'b0);
    @(negedge clk);
    issue_valid = 1'b0;
    cdb_grant   = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    age_q.delete();
    @(negedge clk);
    rst = 1'b0;
    idle(2, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] c;
      logic [XLEN-1:0] a, b;
      c = code_tab[$urandom_range(0, 11)];
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      cycle($urandom_range(0, 9) < 7, c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            a, b, TAG_W'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3,
            1'b0, '0);
    end
    idle(5, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
